// File: rtl/boot_pkg.sv
// Shared state encodings and baud-rate derivation for the UART boot loader.
package boot_pkg;

  typedef logic [2:0] state_t;
  localparam state_t LEN0 = 3'd0;
  localparam state_t LEN1 = 3'd1;
  localparam state_t DATA = 3'd2;
  localparam state_t DONE = 3'd3;
  localparam state_t ERR  = 3'd4;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t IDLE  = 2'd0;
  localparam rx_state_t START = 2'd1;
  localparam rx_state_t BITS  = 2'd2;
  localparam rx_state_t STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, baud counter and bit FSM producing byte/error pulses.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic        sync1;
  logic        sync2;
  logic        prev;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      prev      <= sync2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        // Edge-triggered start so a line left low after a bad stop bit does not retrigger.
        IDLE: begin
          if (prev && !sync2) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (sync2) begin
              state <= IDLE;
            end else begin
              state   <= BITS;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BITS: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
            if (sync2) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed program image from UART into instruction memory and
// holds the core in reset until the image is complete.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int BAUD      = 115_200,
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              error
);

  localparam int          CPB     = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              frame_err;
  state_t            state;
  logic [15:0]       len;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       shreg;
  logic [15:0]       new_len;
  logic [15:0]       addr_ext;
  logic [31:0]       next_word;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

  assign new_len   = {rx_byte, len[7:0]};
  assign addr_ext  = 16'(mem_addr);
  assign next_word = {rx_byte, shreg[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LEN0;
      len       <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      shreg     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN0: begin
          if (frame_err) begin
            state <= ERR;
          end else if (rx_valid) begin
            len[7:0] <= rx_byte;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (frame_err) begin
            state <= ERR;
          end else if (rx_valid) begin
            len[15:8] <= rx_byte;
            byte_cnt  <= '0;
            word_idx  <= '0;
            if (new_len == 16'd0)         state <= DONE;
            else if (new_len > MAX_LEN)   state <= ERR;
            else                          state <= DATA;
          end
        end
        DATA: begin
          if (frame_err) begin
            state <= ERR;
          end else if (mem_we && addr_ext == len - 16'd1) begin
            // Finish in the cycle after the final strobe so no write goes past len-1.
            state <= DONE;
          end else if (rx_valid) begin
            shreg    <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx;
              mem_wdata <= next_word;
              word_idx  <= word_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rst_n = (state == DONE);
  assign busy       = (state == LEN1) || (state == DATA);
  assign error      = (state == ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: serial byte sender plus write-strobe monitor.
module tb_uart_boot_loader;

  localparam int CPB = 104;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        error;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int we_count = 0;
  int last_we_cyc = -1;
  int rise_cyc = -1;
  logic core_prev = 1'b0;
  logic [9:0]  wa [64];
  logic [31:0] wd [64];

  uart_boot_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa[we_count % 64] = mem_addr;
      wd[we_count % 64] = mem_wdata;
      $display("write addr=%0d data=%08h cycle=%0d", mem_addr, mem_wdata, cyc);
      we_count = we_count + 1;
      last_we_cyc = cyc;
    end
    if (core_rst_n === 1'b1 && core_prev === 1'b0) rise_cyc = cyc;
    core_prev = core_rst_n;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    $display("sent byte %02h stop=%0b", b, stop_bit);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_program;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 10'd0) $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata: got %08h want 0", mem_wdata); else n_pass++;
    n_total++; if (core_rst_n !== 1'b0) $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_load;
    int base;
    base = we_count;
    send_byte(8'h02);
    @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL load_busy_len: got %b want 1", busy); else n_pass++;
    send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    repeat (3) @(negedge clk);
    n_total++; if (mem_wdata !== 32'h0050_0093) $display("FAIL load_hold_wdata: got %08h want 00500093", mem_wdata); else n_pass++;
    n_total++; if (core_rst_n !== 1'b0) $display("FAIL load_core_held: got %b want 0", core_rst_n); else n_pass++;
    send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
    repeat (10) @(negedge clk);
    n_total++; if (we_count - base !== 2) $display("FAIL load_strobes: got %0d want 2", we_count - base); else n_pass++;
    n_total++; if (wa[base % 64] !== 10'd0) $display("FAIL load_addr0: got %0d want 0", wa[base % 64]); else n_pass++;
    n_total++; if (wd[base % 64] !== 32'h0050_0093) $display("FAIL load_data0: got %08h want 00500093", wd[base % 64]); else n_pass++;
    n_total++; if (wa[(base + 1) % 64] !== 10'd1) $display("FAIL load_addr1: got %0d want 1", wa[(base + 1) % 64]); else n_pass++;
    n_total++; if (wd[(base + 1) % 64] !== 32'h00A0_0113) $display("FAIL load_data1: got %08h want 00a00113", wd[(base + 1) % 64]); else n_pass++;
    n_total++; if (rise_cyc !== last_we_cyc + 1) $display("FAIL load_release_timing: got cycle %0d want %0d", rise_cyc, last_we_cyc + 1); else n_pass++;
    n_total++; if (core_rst_n !== 1'b1) $display("FAIL load_core_rst_n: got %b want 1", core_rst_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL load_busy_done: got %b want 0", busy); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL load_error: got %b want 0", error); else n_pass++;
  endtask

  task automatic test_zero_len;
    int base;
    do_reset();
    base = we_count;
    send_byte(8'h00); send_byte(8'h00);
    repeat (10) @(negedge clk);
    n_total++; if (we_count - base !== 0) $display("FAIL zero_strobes: got %0d want 0", we_count - base); else n_pass++;
    n_total++; if (core_rst_n !== 1'b1) $display("FAIL zero_core_rst_n: got %b want 1", core_rst_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_oversize;
    int base;
    do_reset();
    base = we_count;
    send_byte(8'h01); send_byte(8'h04);
    repeat (10) @(negedge clk);
    n_total++; if (error !== 1'b1) $display("FAIL oversize_error: got %b want 1", error); else n_pass++;
    n_total++; if (core_rst_n !== 1'b0) $display("FAIL oversize_core: got %b want 0", core_rst_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL oversize_busy: got %b want 0", busy); else n_pass++;
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    repeat (10) @(negedge clk);
    n_total++; if (we_count - base !== 0) $display("FAIL oversize_strobes: got %0d want 0", we_count - base); else n_pass++;
    n_total++; if (error !== 1'b1) $display("FAIL oversize_sticky: got %b want 1", error); else n_pass++;
  endtask

  task automatic test_framing;
    int base;
    do_reset();
    base = we_count;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h93);
    send_frame(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    n_total++; if (error !== 1'b1) $display("FAIL frame_error: got %b want 1", error); else n_pass++;
    n_total++; if (we_count - base !== 0) $display("FAIL frame_strobes: got %0d want 0", we_count - base); else n_pass++;
    n_total++; if (core_rst_n !== 1'b0) $display("FAIL frame_core: got %b want 0", core_rst_n); else n_pass++;
  endtask

  task automatic test_glitch;
    int base;
    do_reset();
    base = we_count;
    uart_rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL glitch_error: got %b want 0", error); else n_pass++;
    send_program();
    n_total++; if (we_count - base !== 2) $display("FAIL glitch_strobes: got %0d want 2", we_count - base); else n_pass++;
    n_total++; if (wa[base % 64] !== 10'd0) $display("FAIL glitch_addr0: got %0d want 0", wa[base % 64]); else n_pass++;
    n_total++; if (core_rst_n !== 1'b1) $display("FAIL glitch_core: got %b want 1", core_rst_n); else n_pass++;
  endtask

  task automatic test_midload_reset;
    int base;
    do_reset();
    base = we_count;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
    @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL midload_busy_before: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL midload_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL midload_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (core_rst_n !== 1'b0) $display("FAIL midload_core: got %b want 0", core_rst_n); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL midload_error: got %b want 0", error); else n_pass++;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_total++; if (we_count - base !== 0) $display("FAIL midload_no_write: got %0d want 0", we_count - base); else n_pass++;
    send_program();
    n_total++; if (we_count - base !== 2) $display("FAIL reload_strobes: got %0d want 2", we_count - base); else n_pass++;
    n_total++; if (wa[base % 64] !== 10'd0) $display("FAIL reload_addr0: got %0d want 0", wa[base % 64]); else n_pass++;
    n_total++; if (wd[(base + 1) % 64] !== 32'h00A0_0113) $display("FAIL reload_data1: got %08h want 00a00113", wd[(base + 1) % 64]); else n_pass++;
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    repeat (10) @(negedge clk);
    n_total++; if (we_count - base !== 2) $display("FAIL after_done_strobes: got %0d want 2", we_count - base); else n_pass++;
    n_total++; if (core_rst_n !== 1'b1) $display("FAIL after_done_core: got %b want 1", core_rst_n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_zero_len();
    test_oversize();
    test_framing();
    test_glitch();
    test_midload_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
